lcd_refresh_sequencer: RTL and testbench
========================================

LCD_REFRESH_SEQUENCER -- requirements
Module: lcd_refresh_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- TICK_DIV, 1000, clocks per LCD bus slot (minimum 4).
- POWERUP_SLOTS, 40, idle slots after reset before the first command.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, system clock.
- rst, in, 1, reset.
- line1_text, in, 128, 16 ASCII chars; [127:120] is column 0.
- line2_text, in, 128, same layout for row 2.
- ddram_address, in, 7, final cursor DDRAM address.
- refresh_req, in, 1, one-cycle request to rewrite both lines.
- lcd_e, out, 1, LCD enable strobe.
- lcd_rs, out, 1, 0 = command, 1 = data.
- lcd_rw, out, 1, always 0 (write only).
- lcd_data, out, 8, LCD data bus.
- busy, out, 1, high whenever the sequencer is not in IDLE.
- refresh_done, out, 1, one-cycle pulse when a refresh completes.
REQ-003 The block SHALL use one clock, clk; reset rst SHALL be asynchronous and active-low.

Function
REQ-004 Slot timing: a counter SHALL run 0..TICK_DIV-1; state advances only on the cycle where the counter equals TICK_DIV-1.
REQ-005 lcd_rs and lcd_data SHALL be stable for the whole slot.
REQ-006 lcd_e SHALL be 1 when the counter is in [TICK_DIV/4, 3*TICK_DIV/4) in command/data slots, and 0 otherwise.
REQ-007 lcd_e SHALL be 0 throughout PWR_WAIT and IDLE.
REQ-008 States and their bus content SHALL be:
- PWR_WAIT: POWERUP_SLOTS slots.
- FUNC_SET: 0x38.
- DISP_ON: 0x0C.
- ENTRY_MODE: 0x06.
- CLEAR: 0x01, held for 2 slots.
- IDLE.
- L1_ADDR: 0x80.
- L1_DATA: 16 slots, rs = 1.
- L2_ADDR: 0xC0.
- L2_DATA: 16 slots, rs = 1.
- CURSOR: 0x80 | ddram_address.
REQ-009 Transitions SHALL be:
- PWR_WAIT -> FUNC_SET -> DISP_ON -> ENTRY_MODE -> CLEAR -> L1_ADDR (automatic first refresh).
- IDLE -> L1_ADDR when a request is pending.
- L1_ADDR -> L1_DATA -> L2_ADDR -> L2_DATA -> CURSOR -> IDLE.
REQ-010 A char index (0..15) SHALL step through the data slots; the slot at index i SHALL send byte [127-8i -: 8] of the snapshot.
REQ-011 On entry to L1_ADDR, line1_text, line2_text and ddram_address SHALL be captured into snapshot registers. Input changes during a refresh SHALL NOT affect it.
REQ-012 A refresh_req arriving in any state other than IDLE SHALL set a single pending flag. Multiple requests SHALL collapse into one.
REQ-013 The pending flag SHALL be cleared on entry to L1_ADDR.
REQ-014 A request on the same cycle as CURSOR completes SHALL be kept pending, so one further refresh follows.
REQ-015 refresh_done SHALL pulse for exactly one cycle on the final cycle of the CURSOR slot.
REQ-016 busy SHALL be 1 in every state except IDLE, including PWR_WAIT and init.
REQ-017 A refresh SHALL last 35 slots; init (PWR_WAIT through CLEAR) SHALL last POWERUP_SLOTS+5 slots.

Reset
REQ-018 While rst = 0, the block SHALL hold:
- state PWR_WAIT, slot counter 0, char index 0, pending 0, snapshots 0;
- lcd_e 0, lcd_rs 0, lcd_rw 0, lcd_data 0x00;
- busy 1, refresh_done 0.
REQ-019 Asserting rst mid-transfer, including while lcd_e = 1, SHALL drop lcd_e immediately, and the sequence SHALL restart from PWR_WAIT on release.

Verification (TICK_DIV=4, POWERUP_SLOTS=2)
REQ-020 Power-up: release reset.
- lcd_e first rises at clock 9.
- Command bytes in order: 0x38, 0x0C, 0x06, 0x01 (0x01 held 8 clocks).
- Then 35 lcd_e pulses, and refresh_done at clock 168 after release.
REQ-021 Text order: line1 "ABCDEFGHIJKLMNOP", line2 "0123456789abcdef", ddram_address 0x45.
- Data bytes 0x41..0x50, then 0xC0, then 0x30..0x66 (the line2 characters).
- Final command byte 0xC5.
REQ-022 Snapshot: change line1_text to all 0x20 during L1_DATA index 3 -> the remaining bytes of that refresh are unchanged (0x44..0x50).
REQ-023 Request collapse: 3 refresh_req pulses during one refresh -> exactly one further refresh; 2 refresh_done pulses total.
REQ-024 Mid-transfer reset: assert rst while lcd_e = 1 in L2_DATA -> lcd_e 0 in the same cycle, busy 1; after release the full init sequence repeats.
REQ-025 Idle request: refresh_req in IDLE -> busy rises the next cycle, 35 lcd_e pulses follow, and lcd_rw stays 0 throughout.

Source files
------------

// File: rtl/lcd_refresh_sequencer_if.sv
// Host-side text/request signals plus the write-only character-LCD bus of the refresh sequencer.
// master = sequencer side, slave = host/LCD side.
interface lcd_refresh_sequencer_if;
  logic [127:0] line1_text;
  logic [127:0] line2_text;
  logic [6:0]   ddram_address;
  logic         refresh_req;
  logic         lcd_e;
  logic         lcd_rs;
  logic         lcd_rw;
  logic [7:0]   lcd_data;
  logic         busy;
  logic         refresh_done;

  modport master (
    input  line1_text, line2_text, ddram_address, refresh_req,
    output lcd_e, lcd_rs, lcd_rw, lcd_data, busy, refresh_done
  );

  modport slave (
    output line1_text, line2_text, ddram_address, refresh_req,
    input  lcd_e, lcd_rs, lcd_rw, lcd_data, busy, refresh_done
  );
endinterface

// File: rtl/lcd_refresh_sequencer.sv
// Initialises a 2x16 character LCD after power-up, then rewrites both text rows and the cursor
// address on request, one bus slot of TICK_DIV clocks per command or data byte.
module lcd_refresh_sequencer #(
  parameter int TICK_DIV      = 1000,
  parameter int POWERUP_SLOTS = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  lcd_refresh_sequencer_if.master bus
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WW = $clog2(POWERUP_SLOTS + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] E_LO     = CW'(TICK_DIV / 4);
  localparam logic [CW-1:0] E_HI     = CW'((3 * TICK_DIV) / 4);
  localparam logic [WW-1:0] PWR_LAST = WW'(POWERUP_SLOTS - 1);

  typedef enum logic [3:0] {
    PWR_WAIT   = 4'd0,
    FUNC_SET   = 4'd1,
    DISP_ON    = 4'd2,
    ENTRY_MODE = 4'd3,
    CLEAR      = 4'd4,
    IDLE       = 4'd5,
    L1_ADDR    = 4'd6,
    L1_DATA    = 4'd7,
    L2_ADDR    = 4'd8,
    L2_DATA    = 4'd9,
    CURSOR     = 4'd10
  } state_t;

  function automatic logic [7:0] char_at(input logic [127:0] text, input logic [3:0] idx);
    logic [127:0] shifted;
    shifted = text << {idx, 3'b000};
    return shifted[127:120];
  endfunction

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic [3:0]     idx_q, idx_d;
  logic           pend_q, pend_d;
  logic [127:0]   snap1_q, snap1_d, snap2_q, snap2_d;
  logic [6:0]     addr_q, addr_d;
  logic           e_q, e_d, rs_q, rs_d, busy_q, busy_d, done_q, done_d, lcd_rw_q;
  logic [7:0]     data_q, data_d;
  logic           tick_s, enter_l1_s, bus_slot_s;

  // Next-state, snapshot and bus-content logic; outputs are derived from the next state so the
  // registered bus lines up exactly with the slot counter.
  always_comb begin
    tick_s  = (cnt_q == CNT_LAST);
    state_d = state_q;
    cnt_d   = tick_s ? {CW{1'b0}} : cnt_q + CW'(1);
    wait_d  = wait_q;
    idx_d   = idx_q;
    case (state_q)
      PWR_WAIT: begin
        if (tick_s && (wait_q == PWR_LAST)) begin
          state_d = FUNC_SET;
          wait_d  = {WW{1'b0}};
        end else if (tick_s) begin
          wait_d = wait_q + WW'(1);
        end else begin
          wait_d = wait_q;
        end
      end
      FUNC_SET:   state_d = tick_s ? DISP_ON : FUNC_SET;
      DISP_ON:    state_d = tick_s ? ENTRY_MODE : DISP_ON;
      ENTRY_MODE: state_d = tick_s ? CLEAR : ENTRY_MODE;
      CLEAR: begin
        if (tick_s && (wait_q == WW'(1))) begin
          state_d = L1_ADDR;
          wait_d  = {WW{1'b0}};
        end else if (tick_s) begin
          wait_d = wait_q + WW'(1);
        end else begin
          wait_d = wait_q;
        end
      end
      // IDLE parks the counter on its last value so a request starts a fresh slot next edge.
      IDLE: begin
        if (bus.refresh_req || pend_q) begin
          state_d = L1_ADDR;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = CNT_LAST;
        end
      end
      L1_ADDR: state_d = tick_s ? L1_DATA : L1_ADDR;
      L1_DATA: begin
        if (tick_s) begin
          idx_d   = idx_q + 4'd1;
          state_d = (idx_q == 4'd15) ? L2_ADDR : L1_DATA;
        end else begin
          idx_d = idx_q;
        end
      end
      L2_ADDR: state_d = tick_s ? L2_DATA : L2_ADDR;
      L2_DATA: begin
        if (tick_s) begin
          idx_d   = idx_q + 4'd1;
          state_d = (idx_q == 4'd15) ? CURSOR : L2_DATA;
        end else begin
          idx_d = idx_q;
        end
      end
      CURSOR: state_d = tick_s ? IDLE : CURSOR;
      default: begin
        state_d = PWR_WAIT;
        cnt_d   = {CW{1'b0}};
      end
    endcase

    enter_l1_s = (state_d == L1_ADDR) && (state_q != L1_ADDR);
    if (enter_l1_s) begin
      pend_d = 1'b0;
    end else if (bus.refresh_req && (state_q != IDLE)) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
    snap1_d = enter_l1_s ? bus.line1_text    : snap1_q;
    snap2_d = enter_l1_s ? bus.line2_text    : snap2_q;
    addr_d  = enter_l1_s ? bus.ddram_address : addr_q;

    bus_slot_s = 1'b1;
    rs_d       = 1'b0;
    data_d     = 8'h00;
    case (state_d)
      FUNC_SET:   data_d = 8'h38;
      DISP_ON:    data_d = 8'h0C;
      ENTRY_MODE: data_d = 8'h06;
      CLEAR:      data_d = 8'h01;
      L1_ADDR:    data_d = 8'h80;
      L1_DATA: begin
        rs_d   = 1'b1;
        data_d = char_at(snap1_d, idx_d);
      end
      L2_ADDR:    data_d = 8'hC0;
      L2_DATA: begin
        rs_d   = 1'b1;
        data_d = char_at(snap2_d, idx_d);
      end
      CURSOR:     data_d = 8'h80 | {1'b0, addr_d};
      default:    bus_slot_s = 1'b0;
    endcase
    e_d    = bus_slot_s && (cnt_d >= E_LO) && (cnt_d < E_HI);
    busy_d = (state_d != IDLE);
    done_d = (state_d == CURSOR) && (cnt_d == CNT_LAST);
  end

  // State, snapshot and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= PWR_WAIT;
      cnt_q    <= {CW{1'b0}};
      wait_q   <= {WW{1'b0}};
      idx_q    <= 4'd0;
      pend_q   <= 1'b0;
      snap1_q  <= 128'd0;
      snap2_q  <= 128'd0;
      addr_q   <= 7'd0;
      e_q      <= 1'b0;
      rs_q     <= 1'b0;
      data_q   <= 8'h00;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      lcd_rw_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      snap1_q  <= snap1_d;
      snap2_q  <= snap2_d;
      addr_q   <= addr_d;
      e_q      <= e_d;
      rs_q     <= rs_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      lcd_rw_q <= 1'b0;
    end
  end

  assign bus.lcd_e        = e_q;
  assign bus.lcd_rs       = rs_q;
  assign bus.lcd_rw       = lcd_rw_q;
  assign bus.lcd_data     = data_q;
  assign bus.busy         = busy_q;
  assign bus.refresh_done = done_q;
endmodule

// File: tb/tb_lcd_refresh_sequencer.sv
// Directed bench for lcd_refresh_sequencer with TICK_DIV=4, POWERUP_SLOTS=2: power-up timing,
// byte order, snapshotting, request collapsing, cursor-edge requests and mid-transfer reset.
module tb_lcd_refresh_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lcd_refresh_sequencer_if bus();
  lcd_refresh_sequencer #(.TICK_DIV(4), .POWERUP_SLOTS(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [8:0] seen_q[$];
  logic [8:0] exp_q[$];
  int done_cnt = 0;
  int rw_bad = 0;
  int unstable = 0;
  logic e_prev = 1'b0;
  logic [8:0] held = 9'h000;

  // Bus monitor: records {rs,data} at each lcd_e rise and checks it holds until lcd_e falls.
  always @(posedge clk) begin
    #2;
    if (bus.lcd_e && !e_prev) begin
      seen_q.push_back({bus.lcd_rs, bus.lcd_data});
      held <= {bus.lcd_rs, bus.lcd_data};
    end else if ((bus.lcd_e || e_prev) && rst && ({bus.lcd_rs, bus.lcd_data} != held)) begin
      unstable <= unstable + 1;
    end
    if (bus.refresh_done === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.lcd_rw !== 1'b0) rw_bad <= rw_bad + 1;
    e_prev <= bus.lcd_e;
  end

  task automatic step();
    @(posedge clk);
    #4;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h001);
  endtask

  task automatic push_refresh(input logic [127:0] l1, input logic [127:0] l2, input logic [6:0] a);
    exp_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l1[127-8*i -: 8]});
    exp_q.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l2[127-8*i -: 8]});
    exp_q.push_back({1'b0, 8'h80 | {1'b0, a}});
  endtask

  task automatic cmp_bytes(input string tag, input int base);
    logic [8:0] got;
    check({tag, "_len"}, seen_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < seen_q.size()) ? seen_q[base + i] : 9'h1FF;
      check($sformatf("%s[%0d]", tag, i), {23'd0, got}, {23'd0, exp_q[i]});
    end
    exp_q.delete();
  endtask

  task automatic wait_done(input int target, input int d0, input int bound);
    int k;
    k = 0;
    while ((done_cnt - d0 < target) && (k < bound)) begin
      step();
      k++;
    end
  endtask

  // Release reset and time the first lcd_e rise and the first refresh_done from that point.
  task automatic powerup(input string tag, input logic [127:0] t1, input logic [127:0] t2);
    int base, first_e, first_done;
    base = seen_q.size();
    first_e = 0;
    first_done = 0;
    rst = 1'b1;
    for (int c = 1; c <= 300 && first_done == 0; c++) begin
      step();
      if (bus.lcd_e && first_e == 0) first_e = c;
      if (bus.refresh_done && first_done == 0) first_done = c;
      if (c == 5) check({tag, "_pwr_wait_busy"}, bus.busy, 1);
    end
    check({tag, "_first_e_clk9"}, first_e, 9);
    // The one-cycle done pulse occupies the cycle that ends at clock edge 168.
    check({tag, "_done_before_clk168"}, first_done, 167);
    push_init();
    push_refresh(t1, t2, 7'h45);
    cmp_bytes({tag, "_bytes"}, base);
  endtask

  initial begin
    logic [127:0] t1, t2, sp;
    int base, d0, k, first_done;
    t1 = "ABCDEFGHIJKLMNOP";
    t2 = "0123456789abcdef";
    sp = {16{8'h20}};
    rst = 1'b0;
    bus.line1_text = t1;
    bus.line2_text = t2;
    bus.ddram_address = 7'h45;
    bus.refresh_req = 1'b0;
    repeat (3) step();
    check("rst_lcd_e", bus.lcd_e, 0);
    check("rst_lcd_rs", bus.lcd_rs, 0);
    check("rst_lcd_rw", bus.lcd_rw, 0);
    check("rst_lcd_data", bus.lcd_data, 0);
    check("rst_busy", bus.busy, 1);
    check("rst_done", bus.refresh_done, 0);

    powerup("pwrup", t1, t2);
    step();
    check("idle_busy_low", bus.busy, 0);
    check("idle_done_low", bus.refresh_done, 0);

    // Request from IDLE
    base = seen_q.size();
    d0 = done_cnt;
    bus.refresh_req = 1'b1;
    step();
    bus.refresh_req = 1'b0;
    check("idle_req_busy_next", bus.busy, 1);
    first_done = 0;
    for (int c = 2; c <= 300 && first_done == 0; c++) begin
      step();
      if (bus.refresh_done) first_done = c;
    end
    check("idle_req_done_cycle", first_done, 140);
    push_refresh(t1, t2, 7'h45);
    cmp_bytes("idle_req", base);
    check("idle_req_one_done", done_cnt - d0, 1);
    step();

    // Snapshot isolation plus three collapsed requests during one refresh
    base = seen_q.size();
    d0 = done_cnt;
    bus.refresh_req = 1'b1;
    step();
    bus.refresh_req = 1'b0;
    k = 0;
    while ((seen_q.size() - base < 5) && (k < 100)) begin
      step();
      k++;
    end
    bus.line1_text = sp;
    repeat (3) begin
      step();
      bus.refresh_req = 1'b1;
      step();
      bus.refresh_req = 1'b0;
      step();
    end
    wait_done(2, d0, 500);
    repeat (20) step();
    check("collapse_two_done", done_cnt - d0, 2);
    check("collapse_idle_after", bus.busy, 0);
    push_refresh(t1, t2, 7'h45);
    push_refresh(sp, t2, 7'h45);
    cmp_bytes("snap_collapse", base);

    // Request on the very edge that completes CURSOR
    d0 = done_cnt;
    bus.line1_text = t1;
    bus.refresh_req = 1'b1;
    step();
    bus.refresh_req = 1'b0;
    k = 0;
    while (!bus.refresh_done && k < 200) begin
      step();
      k++;
    end
    check("cursor_done_seen", bus.refresh_done, 1);
    bus.refresh_req = 1'b1;
    step();
    bus.refresh_req = 1'b0;
    check("cursor_req_idle_gap", bus.busy, 0);
    step();
    check("cursor_req_restart", bus.busy, 1);
    wait_done(2, d0, 300);
    repeat (10) step();
    check("cursor_req_two_done", done_cnt - d0, 2);
    check("cursor_req_idle_after", bus.busy, 0);

    // Reset while lcd_e is high in L2_DATA
    base = seen_q.size();
    bus.refresh_req = 1'b1;
    step();
    bus.refresh_req = 1'b0;
    k = 0;
    while (!((seen_q.size() - base >= 19) && bus.lcd_e) && k < 200) begin
      step();
      k++;
    end
    check("l2_data_e_high", bus.lcd_e, 1);
    check("l2_data_rs", bus.lcd_rs, 1);
    rst = 1'b0;
    #1;
    check("midreset_e_low", bus.lcd_e, 0);
    check("midreset_busy", bus.busy, 1);
    check("midreset_data", bus.lcd_data, 0);
    repeat (2) step();
    powerup("rerun", t1, t2);

    check("bus_stable", unstable, 0);
    check("rw_never_high", rw_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
